// File: rtl/soc_evt_pkg.sv
// Shared types and constants for the SoC-to-cluster event token transmitter.
package soc_evt_pkg;

   localparam int EVNT_WIDTH_DEF = 8;

   typedef logic [EVNT_WIDTH_DEF-1:0] evt_id_t;

   // Reset value of the last-granted index, so that channel 0 is searched first.
   function automatic int last_gnt_rst(input int nb_ch);
      return nb_ch - 1;
   endfunction

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/soc_evt_rr_arb.sv
// Stateless round-robin arbiter: the search starts one past the last grant.
module soc_evt_rr_arb
   import soc_evt_pkg::*;
#(
   parameter int NB_CH = 4,
   parameter int IDX_W = 2
) (
   input  logic [NB_CH-1:0] i_req,
   input  logic [IDX_W-1:0] i_last_gnt,
   input  logic             i_enable,
   output logic [NB_CH-1:0] o_gnt,
   output logic [IDX_W-1:0] o_gnt_idx
);

   logic             w_found;
   logic [IDX_W-1:0] w_cand;

   always_comb begin
      o_gnt     = '0;
      o_gnt_idx = '0;
      w_found   = 1'b0;
      w_cand    = '0;
      for (int i = 1; i <= NB_CH; i++) begin
         w_cand = IDX_W'((int'(i_last_gnt) + i) % NB_CH);
         if (i_enable && !w_found && i_req[w_cand]) begin
            w_found        = 1'b1;
            o_gnt[w_cand]  = 1'b1;
            o_gnt_idx      = w_cand;
         end
      end
   end

endmodule

// File: rtl/soc_evt_token_tx.sv
// Arbitrates SoC event requesters into a slot buffer and publishes each slot to
// the cluster domain through a per-slot toggle token (wt) and returned read pointer (rp).
module soc_evt_token_tx
   import soc_evt_pkg::*;
#(
   parameter int NB_CH        = 4,
   parameter int EVNT_WIDTH   = 8,
   parameter int BUFFER_WIDTH = 8,
   parameter int SYNC_STAGES  = 2
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic [NB_CH-1:0]                     evt_valid_i,
   input  logic [NB_CH*EVNT_WIDTH-1:0]          evt_id_i,
   output logic [NB_CH-1:0]                     evt_ack_o,
   output logic [BUFFER_WIDTH-1:0]              evt_wt_o,
   input  logic [BUFFER_WIDTH-1:0]              evt_rp_i,
   output logic [BUFFER_WIDTH*EVNT_WIDTH-1:0]   evt_da_o,
   output logic [$clog2(BUFFER_WIDTH+1)-1:0]    level_o,
   output logic                                 full_o
);

   localparam int IDX_W = idx_width(NB_CH);
   localparam int WI_W  = $clog2(BUFFER_WIDTH);
   localparam int LVL_W = $clog2(BUFFER_WIDTH+1);
   localparam logic [IDX_W-1:0] LAST_GNT_RST = IDX_W'(last_gnt_rst(NB_CH));
   localparam logic [WI_W-1:0]  WR_IDX_LAST  = WI_W'(BUFFER_WIDTH-1);

   logic [SYNC_STAGES-1:0][BUFFER_WIDTH-1:0] r_rp_sync;
   logic [BUFFER_WIDTH-1:0][EVNT_WIDTH-1:0]  r_slot;
   logic [BUFFER_WIDTH-1:0]                  r_wt;
   logic [WI_W-1:0]                          r_wr_idx;
   logic [IDX_W-1:0]                         r_last_gnt;

   logic [BUFFER_WIDTH-1:0] w_rp;
   logic [BUFFER_WIDTH-1:0] w_occ;
   logic                    w_full;
   logic [LVL_W-1:0]        w_level;
   logic [NB_CH-1:0]        w_gnt;
   logic [IDX_W-1:0]        w_gnt_idx;
   logic                    w_accept;
   logic [EVNT_WIDTH-1:0]   w_id;

   // Receiver read pointer crosses in through a plain per-bit flop chain.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_rp_sync <= '0;
      end else begin
         r_rp_sync <= {r_rp_sync[SYNC_STAGES-2:0], evt_rp_i};
      end
   end

   assign w_rp   = r_rp_sync[SYNC_STAGES-1];
   assign w_occ  = r_wt ^ w_rp;
   assign w_full = w_occ[r_wr_idx];

   always_comb begin
      w_level = '0;
      for (int k = 0; k < BUFFER_WIDTH; k++) begin
         w_level = w_level + LVL_W'(w_occ[k]);
      end
   end

   // Holding off grants during reset keeps every output at zero while rst_i is high.
   soc_evt_rr_arb #(
      .NB_CH (NB_CH),
      .IDX_W (IDX_W)
   ) u_arb (
      .i_req      (evt_valid_i),
      .i_last_gnt (r_last_gnt),
      .i_enable   (~w_full & ~rst_i),
      .o_gnt      (w_gnt),
      .o_gnt_idx  (w_gnt_idx)
   );

   assign w_accept = |w_gnt;

   always_comb begin
      w_id = '0;
      for (int c = 0; c < NB_CH; c++) begin
         if (w_gnt[c]) begin
            w_id = evt_id_i[c*EVNT_WIDTH +: EVNT_WIDTH];
         end
      end
   end

   // Slot data and its token bit update on the same edge, so the data is already
   // stable by the time the toggle reaches any receiver synchroniser.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_slot     <= '0;
         r_wt       <= '0;
         r_wr_idx   <= '0;
         r_last_gnt <= LAST_GNT_RST;
      end else if (w_accept) begin
         r_slot[r_wr_idx] <= w_id;
         r_wt[r_wr_idx]   <= ~r_wt[r_wr_idx];
         r_wr_idx         <= (r_wr_idx == WR_IDX_LAST) ? '0 : r_wr_idx + 1'b1;
         r_last_gnt       <= w_gnt_idx;
      end
   end

   assign evt_ack_o = w_gnt;
   assign evt_wt_o  = r_wt;
   assign evt_da_o  = r_slot;
   assign level_o   = w_level;
   assign full_o    = w_full;

endmodule

// File: tb/tb_soc_evt_token_tx.sv
// Directed bench for soc_evt_token_tx: reset, single event, fill, free, round-robin, simultaneous free/write.
module tb_soc_evt_token_tx;
   import soc_evt_pkg::*;

   localparam int NB_CH = 4;
   localparam int EW    = 8;
   localparam int BW    = 8;
   localparam int SS    = 2;

   logic          clk   = 1'b0;
   logic          rst   = 1'b1;
   logic [3:0]    valid = '0;
   logic [31:0]   ids   = '0;
   logic [7:0]    rp    = '0;
   logic [3:0]    ack;
   logic [7:0]    wt;
   logic [63:0]   da;
   logic [3:0]    level;
   logic          full;

   int n_tests = 0;
   int n_fail  = 0;

   evt_id_t    cur_id [4];
   evt_id_t    exp_id;
   logic [3:0] exp_ack;

   always #5 clk = ~clk;

   soc_evt_token_tx #(
      .NB_CH        (NB_CH),
      .EVNT_WIDTH   (EW),
      .BUFFER_WIDTH (BW),
      .SYNC_STAGES  (SS)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .evt_valid_i (valid),
      .evt_id_i    (ids),
      .evt_ack_o   (ack),
      .evt_wt_o    (wt),
      .evt_rp_i    (rp),
      .evt_da_o    (da),
      .level_o     (level),
      .full_o      (full)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      rp    = '0;
      valid = '0;
      ids   = '0;
      step();
      rst = 1'b0;
      step();
   endtask

   function automatic logic [7:0] slot(input int k);
      return 8'(da >> (k*8));
   endfunction

   initial begin
      repeat (2) step();
      rst = 1'b0;
      step();

      // Reset: one event in flight, then asynchronous reset mid-cycle
      valid = 4'hF;
      ids   = 32'h44332211;
      #1 check("first_ack_ch0", ack, 4'b0001);
      step();
      check("pre_rst_wt", wt, 8'h01);
      #2 rst = 1'b1;
      #1;
      check("rst_wt", wt, 8'h00);
      check("rst_da", da, 64'h0);
      check("rst_ack", ack, 4'b0000);
      check("rst_level", level, 4'd0);
      check("rst_full", full, 1'b0);
      step();
      rst = 1'b0;
      #1 check("post_rst_ack_ch0", ack, 4'b0001);
      valid = '0;
      step();
      check("drop_valid_no_write", wt, 8'h00);

      // Single event from channel 1
      valid = 4'b0010;
      ids   = 32'h00002A00;
      #1 check("single_ack", ack, 4'b0010);
      step();
      valid = '0;
      check("single_wt", wt, 8'h01);
      check("single_slot0", slot(0), 8'h2A);
      check("single_level", level, 4'd1);
      check("single_full", full, 1'b0);

      // Fill: nine back-to-back requests from channel 0, receiver idle
      do_reset();
      valid = 4'b0001;
      for (int i = 0; i < 9; i++) begin
         ids = {24'h0, 8'(8'h80 + i)};
         #1 check($sformatf("fill_ack%0d", i), ack, (i < 8) ? 4'b0001 : 4'b0000);
         step();
      end
      check("fill_wt", wt, 8'hFF);
      check("fill_level", level, 4'd8);
      check("fill_full", full, 1'b1);
      check("fill_da", da, 64'h8786858483828180);

      // Free slot 0: the held ninth event goes through after the synchroniser delay
      rp = 8'h01;
      for (int c = 0; c < SS; c++) begin
         #1 check($sformatf("free_wait%0d", c), ack, 4'b0000);
         step();
      end
      #1 check("free_ack", ack, 4'b0001);
      check("free_level_before", level, 4'd7);
      step();
      valid = '0;
      check("free_wt", wt, 8'hFE);
      check("free_slot0", slot(0), 8'h88);
      check("free_level", level, 4'd8);
      check("free_full", full, 1'b1);

      // Round-robin with a receiver consuming every slot as soon as it is written
      do_reset();
      for (int c = 0; c < 4; c++) cur_id[c] = evt_id_t'(c);
      ids   = {cur_id[3], cur_id[2], cur_id[1], cur_id[0]};
      valid = 4'hF;
      for (int n = 0; n < 10; n++) begin
         exp_ack = 4'b0001 << (n % 4);
         exp_id  = cur_id[n % 4];
         #1 check($sformatf("rr_ack%0d", n), ack, exp_ack);
         step();
         check($sformatf("rr_slot%0d", n), slot(n % 8), exp_id);
         cur_id[n % 4] = cur_id[n % 4] + 8'h10;
         ids = {cur_id[3], cur_id[2], cur_id[1], cur_id[0]};
         rp  = rp ^ (8'h01 << (n % 8));
      end
      valid = '0;

      // Simultaneous: slot 1 free crosses the synchroniser on the edge that writes slot 3
      do_reset();
      valid = 4'b0001;
      for (int i = 0; i < 3; i++) begin
         ids = {24'h0, 8'(8'h30 + i)};
         #1 check($sformatf("sim_fill_ack%0d", i), ack, 4'b0001);
         step();
      end
      valid = '0;
      rp = 8'h02;
      step();
      check("sim_level_pre", level, 4'd3);
      valid = 4'b0001;
      ids   = 32'h0000005A;
      #1 check("sim_ack", ack, 4'b0001);
      step();
      valid = '0;
      check("sim_wt", wt, 8'h0F);
      check("sim_level", level, 4'd3);
      check("sim_full", full, 1'b0);
      check("sim_slot3", slot(3), 8'h5A);
      check("sim_slot1_stable", slot(1), 8'h31);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
